// File: rtl/threshold_out_buffer_if.sv
// threshold_out_buffer_if
//
// Bundles the word path through the output buffer: the capture side fed by
// the threshold processor and the bus side presented to the sink.
//
// Handshake semantics:
//   capture side : every cycle with in_rdy=1 carries one in_data word; there
//                  is no way to stall the producer.
//   bus side     : out_valid/out_ready is a strict valid/ready pair. A word
//                  transfers on every rising clk edge where out_valid and
//                  out_ready are both 1. While out_valid=1 the word on
//                  out_data is held until it transfers. out_valid never
//                  depends combinationally on out_ready.
//
// Signals:
//   in_data   word from the processor's data_out
//   in_rdy    processor's data_out_rdy
//   out_data  head-of-FIFO word, 0 whenever out_valid=0
//   out_valid FIFO non-empty
//   out_ready sink accepts the word this cycle
//
// Modports:
//   master  the buffer (consumes in_*, drives out_data/out_valid)
//   slave   the environment (drives in_* and out_ready)
interface threshold_out_buffer_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_rdy;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      input  in_data,
      input  in_rdy,
      input  out_ready,
      output out_data,
      output out_valid
   );

   modport slave (
      output in_data,
      output in_rdy,
      output out_ready,
      input  out_data,
      input  out_valid
   );
endinterface

// File: rtl/threshold_out_buffer.sv
// threshold_out_buffer
//
// Output buffer that sits directly behind the threshold processor. Every word
// the processor emits during a frame is captured into a first-word
// fall-through FIFO, presented to the sink over valid/ready, and counted
// against a programmed frame length. Once the last word of the frame has been
// drained, done pulses for one cycle. Words that arrive while the FIFO is full
// (and nothing is read in the same cycle) are dropped and set a sticky
// overflow flag.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse, begins a frame (honoured only in IDLE)
//   abort        synchronous flush back to IDLE, highest priority
//   frame_words  words expected this frame, sampled when start is accepted
//   bus          word path (threshold_out_buffer_if.master)
//   busy         high while collecting or draining
//   done         one-cycle pulse once the frame is fully drained
//   overflow     sticky; a word arrived while the FIFO was full
//   level        FIFO occupancy, 0..DEPTH
//   state_dbg    current FSM state (IDLE=0, COLLECT=1, DRAIN=2, DONE=3)
//
// out_valid, out_data, done, busy and level are decoded from registered
// state and pointers only; out_ready and in_rdy influence next-state only.
module threshold_out_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [CNT_WIDTH-1:0]     frame_words,
   threshold_out_buffer_if.master   bus,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level,
   output logic [1:0]               state_dbg
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t                state_q;
   state_t                state_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr_q;
   logic [PW-1:0]         rd_ptr_q;
   logic [PW-1:0]         level_w;

   logic [CNT_WIDTH-1:0]  in_cnt_q;
   logic [CNT_WIDTH-1:0]  frame_q;
   logic                  overflow_q;

   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  rd_en;
   logic                  wr_en;
   logic                  in_evt;
   logic                  last_word;
   logic                  drop;
   logic                  start_acc;

   // ---------------------------------------------------------------------
   // FIFO status. The extra pointer bit is a wrap flag: equal addresses with
   // equal wrap bits mean empty, with differing wrap bits mean full.
   // ---------------------------------------------------------------------
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign level_w    = wr_ptr_q - rd_ptr_q;

   // A read is a completed bus handshake; an empty FIFO never reads because
   // out_valid is low.
   assign rd_en = !fifo_empty && bus.out_ready;

   // Only COLLECT listens to the producer. Once the final word of the frame
   // is seen the FSM leaves COLLECT, so extra words are never counted.
   assign in_evt    = (state_q == ST_COLLECT) && bus.in_rdy;
   assign last_word = in_evt && ((in_cnt_q + CNT_WIDTH'(1)) == frame_q);

   // A full FIFO still accepts a word when a read frees a slot at the same
   // edge; otherwise the word is lost but still counts toward the frame.
   assign wr_en = in_evt && !abort && (!fifo_full || rd_en);
   assign drop  = in_evt && fifo_full && !rd_en;

   assign start_acc = (state_q == ST_IDLE) && start && !abort;

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (frame_words == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_COLLECT;
               end
            end
         end
         ST_COLLECT: begin
            if (last_word) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Finish when the FIFO is already empty or the final word is
            // being handed over at this edge.
            if (fifo_empty || (rd_en && (level_w == PW'(1)))) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (abort) begin
         state_d = ST_IDLE;
      end
   end

   // ---------------------------------------------------------------------
   // Pointers, frame counter and overflow flag
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         in_cnt_q   <= '0;
         frame_q    <= '0;
         overflow_q <= 1'b0;
      end else if (abort) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         in_cnt_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         if (start_acc) begin
            frame_q    <= frame_words;
            in_cnt_q   <= '0;
            overflow_q <= 1'b0;
         end else begin
            if (in_evt) begin
               in_cnt_q <= in_cnt_q + CNT_WIDTH'(1);
            end
            if (drop) begin
               overflow_q <= 1'b1;
            end
         end
      end
   end

   // Storage has no reset; visibility is governed entirely by the pointers.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q[AW-1:0]] <= bus.in_data;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.out_valid = !fifo_empty;
   assign bus.out_data  = fifo_empty ? '0 : mem[rd_ptr_q[AW-1:0]];
   assign busy          = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
   assign done          = (state_q == ST_DONE);
   assign overflow      = overflow_q;
   assign level         = level_w;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_threshold_out_buffer.sv
// tb_threshold_out_buffer
//
// Bench for threshold_out_buffer. A frame-level reference model (a word
// queue plus collect/drain/done flags and a words-left counter) steps on
// every rising edge; a negedge compare process checks every DUT output
// against it each cycle out of reset. Directed scenarios add literal
// expectations, followed by randomized frames with random producer and sink
// activity and occasional aborts.
module tb_threshold_out_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int CW    = 16;

   // ---------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [CW-1:0] frame_words = '0;
   logic          busy;
   logic          done;
   logic          overflow;
   logic [4:0]    level;
   logic [1:0]    state_dbg;

   threshold_out_buffer_if #(.DATA_WIDTH(DW)) bus ();

   threshold_out_buffer #(
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH),
      .CNT_WIDTH (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .frame_words(frame_words),
      .bus        (bus.master),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .level      (level),
      .state_dbg  (state_dbg)
   );

   initial forever #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Counters and checker
   // ---------------------------------------------------------------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: words in flight, frame phase, words still expected
   // ---------------------------------------------------------------------
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] rx_q[$];   // words the model saw handed to the sink
   int            hs_q[$];   // edge number of each of those handshakes
   bit            m_collect = 1'b0;
   bit            m_drain   = 1'b0;
   bit            m_done    = 1'b0;
   bit            m_ovf     = 1'b0;
   int            m_left    = 0;
   int            pcnt      = 0;

   task automatic model_step();
      int sz;
      bit rd;
      bit wr;
      if (!rst_n) begin
         exp_q.delete();
         m_collect = 1'b0;
         m_drain   = 1'b0;
         m_done    = 1'b0;
         m_ovf     = 1'b0;
         m_left    = 0;
      end else begin
         pcnt++;
         if (abort) begin
            exp_q.delete();
            m_collect = 1'b0;
            m_drain   = 1'b0;
            m_done    = 1'b0;
            m_ovf     = 1'b0;
            m_left    = 0;
         end else begin
            sz = exp_q.size();
            rd = (sz > 0) && bus.out_ready;
            wr = 1'b0;
            if (m_done) begin
               m_done = 1'b0;
            end else if (m_collect) begin
               if (bus.in_rdy) begin
                  if (sz < DEPTH || rd) wr = 1'b1;
                  else m_ovf = 1'b1;
                  m_left--;
                  if (m_left == 0) begin
                     m_collect = 1'b0;
                     m_drain   = 1'b1;
                  end
               end
            end else if (m_drain) begin
               if (sz == 0 || (sz == 1 && rd)) begin
                  m_drain = 1'b0;
                  m_done  = 1'b1;
               end
            end else if (start) begin
               m_ovf = 1'b0;
               if (frame_words == 0) m_done = 1'b1;
               else begin
                  m_collect = 1'b1;
                  m_left    = int'(frame_words);
               end
            end
            if (rd) begin
               rx_q.push_back(exp_q.pop_front());
               hs_q.push_back(pcnt);
            end
            if (wr) exp_q.push_back(bus.in_data);
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   // ---------------------------------------------------------------------
   // Per-cycle compare against the model
   // ---------------------------------------------------------------------
   task automatic compare_step();
      bit            e_valid;
      logic [DW-1:0] e_data;
      if (rst_n) begin
         e_valid = (exp_q.size() > 0);
         e_data  = e_valid ? exp_q[0] : '0;
         check("out_valid", 32'(bus.out_valid), 32'(e_valid));
         check("out_data", bus.out_data, e_data);
         check("level", 32'(level), 32'(exp_q.size()));
         check("busy", 32'(busy), 32'(m_collect || m_drain));
         check("done", 32'(done), 32'(m_done));
         check("overflow", 32'(overflow), 32'(m_ovf));
      end
   endtask

   initial forever begin
      @(negedge clk);
      compare_step();
   end

   // ---------------------------------------------------------------------
   // Driver tasks (called at a falling edge, return at the next one)
   // ---------------------------------------------------------------------
   task automatic cyc(input bit st, input bit ab, input logic [CW-1:0] fw,
                      input bit rdy, input logic [DW-1:0] d, input bit ord);
      start         = st;
      abort         = ab;
      frame_words   = fw;
      bus.in_rdy    = rdy;
      bus.in_data   = d;
      bus.out_ready = ord;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
   endtask

   // Sink always ready until done is seen; returns the edge count at which
   // done was visible, or -1 on timeout.
   task automatic wait_done(input int budget, output int done_p);
      bit seen;
      seen   = 1'b0;
      done_p = -1;
      for (int i = 0; i < budget && !seen; i++) begin
         if (done) begin
            seen   = 1'b1;
            done_p = pcnt;
         end else begin
            cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
         end
      end
      check("done_timeout", 32'(seen), 32'd1);
   endtask

   // ---------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------
   initial begin
      int base;
      int d0;
      int dp;

      bus.in_rdy    = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // Reset
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data", bus.out_data, 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);

      // Basic frame of six words, sink always ready
      base = rx_q.size();
      cyc(1'b1, 1'b0, 16'd6, 1'b0, '0, 1'b1);
      d0 = pcnt;
      for (int k = 1; k <= 6; k++) cyc(1'b0, 1'b0, 16'd6, 1'b1, 32'h11111111 * k, 1'b1);
      wait_done(20, dp);
      check("basic_count", 32'(rx_q.size() - base), 32'd6);
      for (int k = 1; k <= 6; k++) check("basic_word", rx_q[base+k-1], 32'h11111111 * k);
      check("basic_first_lat", 32'(hs_q[base]), 32'(d0 + 2));
      check("basic_done_lat", 32'(dp), 32'(hs_q[base+5]));
      check("basic_ovf", 32'(overflow), 32'd0);
      idle(1);

      // Overflow: 20 words into a stalled sink
      base = rx_q.size();
      cyc(1'b1, 1'b0, 16'd20, 1'b0, '0, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         cyc(1'b0, 1'b0, 16'd20, 1'b1, k, 1'b0);
         if (k == 16) begin
            check("ovf_level16", 32'(level), 32'd16);
            check("ovf_not_yet", 32'(overflow), 32'd0);
         end
         if (k == 17) begin
            check("ovf_set17", 32'(overflow), 32'd1);
            check("ovf_level17", 32'(level), 32'd16);
         end
      end
      check("ovf_level_end", 32'(level), 32'd16);
      wait_done(60, dp);
      check("ovf_count", 32'(rx_q.size() - base), 32'd16);
      for (int k = 1; k <= 16; k++) check("ovf_word", rx_q[base+k-1], k);
      check("ovf_sticky_done", 32'(overflow), 32'd1);
      idle(1);
      check("ovf_sticky_idle", 32'(overflow), 32'd1);

      // Full FIFO with simultaneous read and write across the wrap
      base = rx_q.size();
      cyc(1'b1, 1'b0, 16'd24, 1'b0, '0, 1'b0);
      for (int k = 1; k <= 16; k++) cyc(1'b0, 1'b0, 16'd24, 1'b1, 32'h100 + k, 1'b0);
      for (int k = 17; k <= 24; k++) begin
         cyc(1'b0, 1'b0, 16'd24, 1'b1, 32'h100 + k, 1'b1);
         check("full_rw_level", 32'(level), 32'd16);
      end
      check("full_rw_ovf", 32'(overflow), 32'd0);
      wait_done(60, dp);
      check("full_rw_count", 32'(rx_q.size() - base), 32'd24);
      for (int k = 1; k <= 24; k++) check("full_rw_word", rx_q[base+k-1], 32'h100 + k);
      idle(1);

      // Zero-length frame
      cyc(1'b1, 1'b0, 16'd0, 1'b0, '0, 1'b1);
      check("zero_done", 32'(done), 32'd1);
      check("zero_valid", 32'(bus.out_valid), 32'd0);
      idle(1);
      check("zero_done_end", 32'(done), 32'd0);

      // Excess words beyond frame length
      base = rx_q.size();
      cyc(1'b1, 1'b0, 16'd3, 1'b0, '0, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         cyc(1'b0, 1'b0, 16'd3, 1'b1, 32'h300 + k, 1'b0);
         if (k == 3) begin
            check("excess_drain", 32'(state_dbg), 32'd2);
            check("excess_busy", 32'(busy), 32'd1);
         end
      end
      check("excess_level", 32'(level), 32'd3);
      wait_done(20, dp);
      check("excess_count", 32'(rx_q.size() - base), 32'd3);
      for (int k = 1; k <= 3; k++) check("excess_word", rx_q[base+k-1], 32'h300 + k);
      idle(1);

      // Abort after four of eight words
      cyc(1'b1, 1'b0, 16'd8, 1'b0, '0, 1'b0);
      for (int k = 1; k <= 4; k++) cyc(1'b0, 1'b0, 16'd8, 1'b1, 32'h400 + k, 1'b0);
      check("abort_pre_level", 32'(level), 32'd4);
      cyc(1'b0, 1'b1, 16'd8, 1'b1, 32'h405, 1'b0);
      check("abort_valid", 32'(bus.out_valid), 32'd0);
      check("abort_level", 32'(level), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      for (int k = 0; k < 3; k++) begin
         idle(1);
         check("abort_no_done", 32'(done), 32'd0);
      end

      // Asynchronous reset in the middle of DRAIN with overflow set
      cyc(1'b1, 1'b0, 16'd18, 1'b0, '0, 1'b0);
      for (int k = 1; k <= 18; k++) cyc(1'b0, 1'b0, 16'd18, 1'b1, 32'h500 + k, 1'b0);
      check("rstmid_busy", 32'(busy), 32'd1);
      check("rstmid_ovf", 32'(overflow), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_valid", 32'(bus.out_valid), 32'd0);
      check("rstmid_data", bus.out_data, 32'd0);
      check("rstmid_level", 32'(level), 32'd0);
      check("rstmid_busy0", 32'(busy), 32'd0);
      check("rstmid_done", 32'(done), 32'd0);
      check("rstmid_ovf0", 32'(overflow), 32'd0);
      check("rstmid_state", 32'(state_dbg), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Back-to-back frames, first one overflowing
      cyc(1'b1, 1'b0, 16'd18, 1'b0, '0, 1'b0);
      for (int k = 1; k <= 18; k++) cyc(1'b0, 1'b0, 16'd18, 1'b1, 32'h600 + k, 1'b0);
      wait_done(60, dp);
      check("b2b_ovf_first", 32'(overflow), 32'd1);
      idle(1);
      base = rx_q.size();
      cyc(1'b1, 1'b0, 16'd3, 1'b0, '0, 1'b1);
      check("b2b_ovf_clear", 32'(overflow), 32'd0);
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_empty", 32'(level), 32'd0);
      for (int k = 1; k <= 3; k++) cyc(1'b0, 1'b0, 16'd3, 1'b1, 32'h700 + k, 1'b1);
      wait_done(20, dp);
      check("b2b_count", 32'(rx_q.size() - base), 32'd3);
      for (int k = 1; k <= 3; k++) check("b2b_word", rx_q[base+k-1], 32'h700 + k);
      idle(1);

      // Randomized frames
      for (int f = 0; f < 40; f++) begin
         int fw;
         int ab_at;
         bit do_ab;
         bit finished;
         fw       = $urandom_range(0, 24);
         do_ab    = ($urandom_range(0, 9) == 0);
         ab_at    = $urandom_range(0, 30);
         finished = 1'b0;
         cyc(1'b1, 1'b0, fw[CW-1:0], 1'b0, '0, 1'($urandom_range(0, 1)));
         for (int i = 0; i < 400 && !finished; i++) begin
            if (done) begin
               finished = 1'b1;
            end else if (do_ab && i == ab_at) begin
               cyc(1'b0, 1'b1, fw[CW-1:0], 1'b1, $urandom, 1'b0);
               finished = 1'b1;
            end else begin
               cyc(1'b0, 1'b0, fw[CW-1:0], ($urandom_range(0, 9) < 7), $urandom,
                   ($urandom_range(0, 9) < 6));
            end
         end
         check("rand_frame_end", 32'(finished), 32'd1);
         idle(1);
      end

      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
